// File: rtl/logic_net_sequencer.sv
// logic_net_sequencer: steps the two-input gate network through all four input
// vectors, waits a settle window per vector, samples out1 and reports a
// per-vector pass/fail mask against EXP_TABLE.
// Optional feature macro: GLITCH_DETECT_EN (counts out1 transitions inside the
// settle windows; glitch_cnt is tied to zero when the macro is undefined).
module logic_net_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter logic [3:0]  EXP_TABLE     = 4'b1111
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       net_out1,
    output logic       net_in1,
    output logic       net_in2,
    output logic       busy,
    output logic       done,
    output logic [1:0] vector_idx,
    output logic [3:0] sampled,
    output logic [3:0] fail_mask,
    output logic       pass,
    output logic [7:0] glitch_cnt
);

    localparam int unsigned SETTLE_K = SETTLE_CYCLES + SYNC_STAGES;
    localparam int unsigned CNT_W    = ($clog2(SETTLE_K + 1) > 1) ? $clog2(SETTLE_K + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       settle_cnt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   out1_sync;
    logic [3:0]             sampled_upd_c;
    logic [3:0]             fail_upd_c;

    assign out1_sync = sync_q[SYNC_STAGES-1];

    // Bring the asynchronous network output into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= net_out1;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Result vectors with the current vector's sample merged in.
    always_comb begin
        sampled_upd_c             = sampled;
        fail_upd_c                = fail_mask;
        sampled_upd_c[vector_idx] = out1_sync;
        fail_upd_c[vector_idx]    = out1_sync ^ EXP_TABLE[vector_idx];
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            settle_cnt <= '0;
            net_in1    <= 1'b0;
            net_in2    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            vector_idx <= 2'd0;
            sampled    <= 4'd0;
            fail_mask  <= 4'd0;
            pass       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state      <= S_APPLY;
                        vector_idx <= 2'd0;
                        sampled    <= 4'd0;
                        fail_mask  <= 4'd0;
                        pass       <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                S_APPLY: begin
                    net_in1    <= vector_idx[1];
                    net_in2    <= vector_idx[0];
                    settle_cnt <= CNT_W'(SETTLE_K - 1);
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    sampled   <= sampled_upd_c;
                    fail_mask <= fail_upd_c;
                    if (vector_idx == 2'd3) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= ~|fail_upd_c;
                    end else begin
                        vector_idx <= vector_idx + 2'd1;
                        state      <= S_APPLY;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef GLITCH_DETECT_EN
    logic out1_sync_prev;
    logic glitch_window_c;

    // The first SYNC_STAGES settle cycles carry the legitimate vector change
    // through the synchroniser, so only later cycle-to-cycle changes count.
    assign glitch_window_c = (state == S_SETTLE) &&
                             ((32'(settle_cnt) + 32'd1) < SETTLE_CYCLES);

    // Saturating count of synced out1 transitions inside the settle windows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out1_sync_prev <= 1'b0;
            glitch_cnt     <= 8'd0;
        end else begin
            out1_sync_prev <= out1_sync;
            if (state == S_IDLE && start) begin
                glitch_cnt <= 8'd0;
            end else if (glitch_window_c && (out1_sync != out1_sync_prev) &&
                         (glitch_cnt != 8'hFF)) begin
                glitch_cnt <= glitch_cnt + 8'd1;
            end
        end
    end
`else
    assign glitch_cnt = 8'd0;
`endif

endmodule
